// File: rtl/zoom_controlador_if.sv
// ---------------------------------------------------------------------------
// zoom_controlador_if
//
// Bundles the control, source-read and destination-write signals of the
// nearest-neighbour zoom sequencer.
//
//   iniciar    start request (host -> sequencer)
//   fator      zoom factor 0=1x, 1=2x, 2=4x, 3=reserved
//   suspender  stall request, holds new source reads while high
//   src_rd     source read strobe
//   src_addr   source address
//   src_dado   source data, valid the cycle after src_rd
//   dst_we     destination write strobe
//   dst_addr   destination address
//   dst_dado   destination data, valid with dst_we
//   ocupado    frame in progress
//   concluido  one-cycle end-of-frame pulse
//   erro       one-cycle pulse on a reserved fator
//
// master: the sequencer side.  slave: host plus memories.
// ---------------------------------------------------------------------------
interface zoom_controlador_if #(
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19
);
  logic              iniciar;
  logic [1:0]        fator;
  logic              suspender;
  logic              src_rd;
  logic [SRC_AW-1:0] src_addr;
  logic [7:0]        src_dado;
  logic              dst_we;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        dst_dado;
  logic              ocupado;
  logic              concluido;
  logic              erro;

  modport master (
    input  iniciar, fator, suspender, src_dado,
    output src_rd, src_addr, dst_we, dst_addr, dst_dado,
           ocupado, concluido, erro
  );

  modport slave (
    output iniciar, fator, suspender, src_dado,
    input  src_rd, src_addr, dst_we, dst_addr, dst_dado,
           ocupado, concluido, erro
  );
endinterface

// File: rtl/zoom_controlador.sv
// ---------------------------------------------------------------------------
// zoom_controlador
//
// Walks every destination pixel of a frame up-scaled by 1<<k (k = fator)
// in raster order, issuing one source read per pixel at (i>>k, j>>k) and
// writing the returned byte to the destination buffer one cycle later.
// Addresses are built from running row bases, so no multipliers are used.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    zoom_controlador_if.master (control, source read, dest write)
//
// src_rd is the registered read enable gated by suspender, so a stall
// suppresses the read in the very cycle it is asserted.  dst_dado passes
// src_dado through, forced to zero whenever no write is in progress.
// ---------------------------------------------------------------------------
module zoom_controlador #(
  parameter int LARGURA = 160,
  parameter int ALTURA  = 120,
  parameter int SRC_AW  = 15,
  parameter int DST_AW  = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  zoom_controlador_if.master  bus
);

  localparam int J_W  = $clog2(4 * LARGURA);
  localparam int I_W  = $clog2(4 * ALTURA);
  localparam int OJ_W = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    VARRENDO  = 2'd1,
    DRENANDO  = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

  estado_t           estado_q;
  logic [1:0]        k_q;

  // scan counters
  logic [J_W-1:0]    j_q,  j_d;
  logic [I_W-1:0]    i_q,  i_d;
  logic [1:0]        sj_q, sj_d;
  logic [1:0]        si_q, si_d;
  logic [OJ_W-1:0]   oj_q, oj_d;
  logic [SRC_AW-1:0] rb_q, rb_d;
  logic [DST_AW-1:0] db_q, db_d;

  // destination address of the pixel the counters currently point at
  logic [DST_AW-1:0] dst_cur_q;

  // registered outputs
  logic              rd_en_q;
  logic [SRC_AW-1:0] src_addr_q;
  logic              dst_we_q;
  logic [DST_AW-1:0] dst_addr_q;
  logic              ocupado_q;
  logic              concluido_q;
  logic              erro_q;

  // per-factor limits
  logic [1:0]        sub_max;
  logic [J_W-1:0]    j_max;
  logic [I_W-1:0]    i_max;
  logic [DST_AW-1:0] linha_dst;

  logic emite;
  logic fim_j, fim_i, fim_sj, fim_si, ultimo;

  always_comb begin
    case (k_q)
      2'd0: begin
        sub_max   = 2'd0;
        j_max     = J_W'(LARGURA - 1);
        i_max     = I_W'(ALTURA - 1);
        linha_dst = DST_AW'(LARGURA);
      end
      2'd1: begin
        sub_max   = 2'd1;
        j_max     = J_W'(2 * LARGURA - 1);
        i_max     = I_W'(2 * ALTURA - 1);
        linha_dst = DST_AW'(2 * LARGURA);
      end
      default: begin
        sub_max   = 2'd3;
        j_max     = J_W'(4 * LARGURA - 1);
        i_max     = I_W'(4 * ALTURA - 1);
        linha_dst = DST_AW'(4 * LARGURA);
      end
    endcase
  end

  // A read goes out in every VARRENDO cycle that is not stalled.
  assign emite  = rd_en_q & ~bus.suspender;

  assign fim_j  = (j_q == j_max);
  assign fim_i  = (i_q == i_max);
  assign fim_sj = (sj_q == sub_max);
  assign fim_si = (si_q == sub_max);
  assign ultimo = fim_j & fim_i;

  // Counter advance for one issued pixel.
  always_comb begin
    j_d  = j_q;
    i_d  = i_q;
    sj_d = sj_q;
    si_d = si_q;
    oj_d = oj_q;
    rb_d = rb_q;
    db_d = db_q;
    if (fim_j) begin
      j_d  = '0;
      sj_d = 2'd0;
      oj_d = '0;
      db_d = db_q + linha_dst;
      i_d  = i_q + 1'b1;
      // the source line only moves on after 1<<k destination rows
      if (fim_si) begin
        si_d = 2'd0;
        rb_d = rb_q + SRC_AW'(LARGURA);
      end else begin
        si_d = si_q + 2'd1;
      end
    end else begin
      j_d = j_q + 1'b1;
      if (fim_sj) begin
        sj_d = 2'd0;
        oj_d = oj_q + 1'b1;
      end else begin
        sj_d = sj_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      k_q         <= 2'd0;
      j_q         <= '0;
      i_q         <= '0;
      sj_q        <= 2'd0;
      si_q        <= 2'd0;
      oj_q        <= '0;
      rb_q        <= '0;
      db_q        <= '0;
      dst_cur_q   <= '0;
      rd_en_q     <= 1'b0;
      src_addr_q  <= '0;
      dst_we_q    <= 1'b0;
      dst_addr_q  <= '0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      // the write trails each issued read by exactly one cycle
      dst_we_q    <= emite;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
      if (emite) begin
        dst_addr_q <= dst_cur_q;
      end

      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            if (bus.fator == 2'd3) begin
              erro_q <= 1'b1;
            end else begin
              k_q        <= bus.fator;
              j_q        <= '0;
              i_q        <= '0;
              sj_q       <= 2'd0;
              si_q       <= 2'd0;
              oj_q       <= '0;
              rb_q       <= '0;
              db_q       <= '0;
              dst_cur_q  <= '0;
              src_addr_q <= '0;
              rd_en_q    <= 1'b1;
              ocupado_q  <= 1'b1;
              estado_q   <= VARRENDO;
            end
          end
        end

        VARRENDO: begin
          if (emite) begin
            j_q        <= j_d;
            i_q        <= i_d;
            sj_q       <= sj_d;
            si_q       <= si_d;
            oj_q       <= oj_d;
            rb_q       <= rb_d;
            db_q       <= db_d;
            src_addr_q <= rb_d + SRC_AW'(oj_d);
            dst_cur_q  <= db_d + DST_AW'(j_d);
            if (ultimo) begin
              rd_en_q  <= 1'b0;
              estado_q <= DRENANDO;
            end
          end
        end

        DRENANDO: begin
          // final write is on the bus this cycle
          ocupado_q   <= 1'b0;
          concluido_q <= 1'b1;
          estado_q    <= CONCLUIDO;
        end

        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.src_rd    = emite;
  assign bus.src_addr  = src_addr_q;
  assign bus.dst_we    = dst_we_q;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.dst_dado  = dst_we_q ? bus.src_dado : 8'd0;
  assign bus.ocupado   = ocupado_q;
  assign bus.concluido = concluido_q;
  assign bus.erro      = erro_q;

endmodule

// File: tb/tb_zoom_controlador.sv
// ---------------------------------------------------------------------------
// tb_zoom_controlador
//
// Small 4x3 source frame filled with its own address; a table of frame runs
// (factor, stall window, expected write count, expected concluido cycle) plus
// hand-written sequences for reset, reserved factor, mid-frame reset and
// iniciar held high.
// ---------------------------------------------------------------------------
module tb_zoom_controlador;

  localparam int LARG = 4;
  localparam int ALT  = 3;
  localparam int SAW  = 6;
  localparam int DAW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zoom_controlador_if #(.SRC_AW(SAW), .DST_AW(DAW)) bus ();

  zoom_controlador #(
    .LARGURA(LARG), .ALTURA(ALT), .SRC_AW(SAW), .DST_AW(DAW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // source memory: every location holds its own address
  always @(posedge clk) begin
    if (!rst_n)
      bus.src_dado <= 8'd0;
    else if (bus.src_rd)
      bus.src_dado <= 8'(bus.src_addr);
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] dst_mem [0:255];

  typedef struct {
    int k;
    int st_a;
    int st_b;
    int exp_wr;
    int exp_conc;
  } vec_t;

  vec_t tab [7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, expv, $time);
    end
  endtask

  // source address feeding destination pixel number n of the raster scan
  function automatic int exp_src(input int k, input int n);
    int w;
    w = LARG << k;
    return ((n / w) >> k) * LARG + ((n % w) >> k);
  endfunction

  task automatic run_frame(input int k, input int sa, input int sb,
                           input int exp_wr, input int exp_conc);
    int nrd, nwr, conc, last_rd, lim;
    nrd = 0; nwr = 0; conc = -1; last_rd = -1; lim = exp_conc + 20;
    @(negedge clk);
    bus.iniciar = 1'b1; bus.fator = 2'(k); bus.suspender = 1'b0;
    @(negedge clk);
    bus.iniciar = 1'b0;
    for (int cyc = 1; cyc <= lim && conc < 0; cyc++) begin
      bus.suspender = (cyc >= sa && cyc <= sb);
      #1;
      if (bus.suspender) chk("stall_no_rd", 32'(bus.src_rd), 0);
      if (bus.dst_we) begin
        chk("wr_addr", 32'(bus.dst_addr), nwr);
        chk("wr_data", 32'(bus.dst_dado), exp_src(k, nwr));
        if (k == 0) chk("k0_src_eq_dst", 32'(bus.dst_addr), last_rd);
        dst_mem[bus.dst_addr] = bus.dst_dado;
        nwr++;
      end
      if (bus.src_rd) begin
        chk("rd_addr", 32'(bus.src_addr), exp_src(k, nrd));
        last_rd = int'(bus.src_addr);
        nrd++;
      end
      if (bus.concluido) begin
        conc = cyc;
        chk("ocupado_at_conc", 32'(bus.ocupado), 0);
      end else begin
        chk("ocupado_busy", 32'(bus.ocupado), 1);
      end
      @(negedge clk);
    end
    bus.suspender = 1'b0;
    #1;
    chk("concluido_cycle", conc, exp_conc);
    chk("write_count", nwr, exp_wr);
    chk("concluido_one_cycle", 32'(bus.concluido), 0);
    $display("frame k=%0d stall=%0d..%0d writes=%0d concluido_cycle=%0d",
             k, sa, sb, nwr, conc);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_src_rd"},    32'(bus.src_rd), 0);
    chk({nm, "_src_addr"},  32'(bus.src_addr), 0);
    chk({nm, "_dst_we"},    32'(bus.dst_we), 0);
    chk({nm, "_dst_addr"},  32'(bus.dst_addr), 0);
    chk({nm, "_dst_dado"},  32'(bus.dst_dado), 0);
    chk({nm, "_ocupado"},   32'(bus.ocupado), 0);
    chk({nm, "_concluido"}, 32'(bus.concluido), 0);
    chk({nm, "_erro"},      32'(bus.erro), 0);
  endtask

  initial begin
    int conc;
    tab[0] = '{1, 0, -1, 48, 50};
    tab[1] = '{2, 0, -1, 192, 194};
    tab[2] = '{0, 0, -1, 12, 14};
    tab[3] = '{1, 5, 7, 48, 53};
    tab[4] = '{0, 3, 3, 12, 15};
    tab[5] = '{1, 48, 48, 48, 51};   // stall on the last read
    tab[6] = '{0, 13, 14, 12, 14};   // stall in DRENANDO/CONCLUIDO ignored

    bus.iniciar = 1'b0; bus.fator = 2'd0; bus.suspender = 1'b0;
    for (int a = 0; a < 256; a++) dst_mem[a] = 8'hEE;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      run_frame(tab[t].k, tab[t].st_a, tab[t].st_b, tab[t].exp_wr, tab[t].exp_conc);
      if (t == 0) begin
        chk("k1_row0_col7", 32'(dst_mem[7]), 3);
        chk("k1_row1_col1", 32'(dst_mem[9]), 0);
        chk("k1_row2_col0", 32'(dst_mem[16]), 4);
        chk("k1_row2_col1", 32'(dst_mem[17]), 4);
      end
      if (t == 1) chk("k2_dst_5_9", 32'(dst_mem[89]), 6);
    end

    // reserved factor
    @(negedge clk);
    bus.iniciar = 1'b1; bus.fator = 2'd3;
    @(negedge clk);
    bus.iniciar = 1'b0;
    #1;
    chk("erro_pulse", 32'(bus.erro), 1);
    chk("erro_ocupado", 32'(bus.ocupado), 0);
    chk("erro_no_rd", 32'(bus.src_rd), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("erro_after", 32'(bus.erro), 0);
      chk("erro_idle_rd", 32'(bus.src_rd), 0);
      chk("erro_idle_ocupado", 32'(bus.ocupado), 0);
    end
    $display("reserved factor sequence done");

    // reset in cycle 20 of a 2x frame
    @(negedge clk);
    bus.iniciar = 1'b1; bus.fator = 2'd1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk_all_zero("midreset");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk("midreset_no_we", 32'(bus.dst_we), 0);
      chk("midreset_no_conc", 32'(bus.concluido), 0);
    end
    $display("mid-frame reset sequence done");
    run_frame(1, 0, -1, 48, 50);

    // iniciar held high: second frame starts right after concluido
    @(negedge clk);
    bus.iniciar = 1'b1; bus.fator = 2'd0;
    @(negedge clk);
    conc = -1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      #1;
      if (bus.concluido && conc < 0) conc = cyc;
      if (cyc == 15) chk("held_idle_rd", 32'(bus.src_rd), 0);
      if (cyc == 16) begin
        chk("held_restart_rd", 32'(bus.src_rd), 1);
        chk("held_restart_addr", 32'(bus.src_addr), 0);
        chk("held_restart_ocupado", 32'(bus.ocupado), 1);
      end
      @(negedge clk);
    end
    chk("held_first_conc", conc, 14);
    bus.iniciar = 1'b0;
    conc = -1;
    for (int cyc = 17; cyc <= 50 && conc < 0; cyc++) begin
      #1;
      if (bus.concluido) conc = cyc;
      @(negedge clk);
    end
    chk("held_second_conc", conc, 29);
    $display("held iniciar sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
